lfsr_checker: RTL and testbench

Receive-side PRBS checker for the 32-bit LFSR pattern generator. It observes the 16-bit per-cycle slice of the generator state that appears on the chip pins and self-synchronises a local shadow LFSR to it. Once locked, it predicts every subsequent sample and counts bit errors. It sits behind the input pins, or in loopback, as the pass/fail monitor for pattern tests.

---
 rtl/lfsr_checker_if.sv | 16 +
 rtl/lfsr_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// Receive-side sample bus for the PRBS checker.
// Master drives one LFSR slice per valid cycle.
interface lfsr_checker_if;
  logic [15:0] data_i;
  logic        valid_i;

  modport master (
    output data_i,
    output valid_i
  );

  modport slave (
    input data_i,
    input valid_i
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for a 32-bit Fibonacci LFSR.
// Acquires from two 16-bit slices, then free-runs and counts bit errors.
module lfsr_checker #(
  parameter logic [31:0] TAPS        = 32'h8020_0003,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  lfsr_checker_if.slave bus,
  input  logic          clear_i,
  output logic          locked_o,
  output logic          err_o,
  output logic [4:0]    err_bits_o,
  output logic [15:0]   err_count_o,
  output logic [15:0]   word_count_o
);

  typedef enum logic [1:0] {
    HUNT,
    FILL,
    LOCKED
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] shadow_q;
  logic [15:0] hold_q;
  logic [3:0]  fill_q;
  logic [3:0]  miss_q;

  logic [31:0] pred;
  logic [15:0] e;
  logic [4:0]  bits;
  logic        check;
  logic        bad;
  logic        lose;
  logic        fill_done;
  logic        load_zero;
  logic [16:0] err_sum;

  assign pred      = {shadow_q[30:0], ^(shadow_q & TAPS)};
  assign e         = pred[15:0] ^ bus.data_i;
  assign check     = bus.valid_i && (state_q == LOCKED);
  assign bad       = (e != 16'd0);
  assign lose      = check && bad &&
                     ((miss_q + 4'd1) == 4'(LOSS_THRESH));
  assign fill_done = bus.valid_i && (state_q == FILL) &&
                     (fill_q == 4'd15);
  assign load_zero = ({hold_q, bus.data_i} == 32'd0);
  assign err_sum   = {1'b0, err_count_o} + 17'(bits);

  always_comb begin
    bits = 5'd0;
    for (int i = 0; i < 16; i++) begin
      bits = bits + 5'(e[i]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (bus.valid_i) state_d = FILL;
      end
      FILL: begin
        if (fill_done) state_d = load_zero ? HUNT : LOCKED;
      end
      LOCKED: begin
        if (lose) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      shadow_q     <= 32'd0;
      hold_q       <= 16'd0;
      fill_q       <= 4'd0;
      miss_q       <= 4'd0;
      locked_o     <= 1'b0;
      err_o        <= 1'b0;
      err_bits_o   <= 5'd0;
      err_count_o  <= 16'd0;
      word_count_o <= 16'd0;
    end else begin
      locked_o <= (state_d == LOCKED);
      err_o    <= check && bad;
      if (bus.valid_i) begin
        unique case (state_q)
          HUNT: begin
            hold_q <= bus.data_i;
            fill_q <= 4'd0;
          end
          FILL: begin
            fill_q <= fill_q + 4'd1;
            if (fill_done) shadow_q <= {hold_q, bus.data_i};
          end
          LOCKED: begin
            // shadow free-runs on its own prediction, never on data
            shadow_q <= pred;
            if (lose || !bad) miss_q <= 4'd0;
            else              miss_q <= miss_q + 4'd1;
          end
          default: ;
        endcase
      end
      if (check) err_bits_o <= bits;
      if (clear_i) begin
        err_count_o  <= 16'd0;
        word_count_o <= 16'd0;
      end else if (check) begin
        if (word_count_o != 16'hFFFF) begin
          word_count_o <= word_count_o + 16'd1;
        end
        err_count_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker.
// Reference generator is a plain 32-bit Fibonacci LFSR.
module tb_lfsr_checker;

  logic        clk;
  logic        reset_i;
  logic        clear_i;
  logic        locked_o;
  logic        err_o;
  logic [4:0]  err_bits_o;
  logic [15:0] err_count_o;
  logic [15:0] word_count_o;

  lfsr_checker_if bus ();

  lfsr_checker dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .bus          (bus),
    .clear_i      (clear_i),
    .locked_o     (locked_o),
    .err_o        (err_o),
    .err_bits_o   (err_bits_o),
    .err_count_o  (err_count_o),
    .word_count_o (word_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;
  logic [31:0] gen;

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic clr);
    bus.valid_i = v;
    bus.data_i  = d;
    clear_i     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] mask);
    drive(1'b1, gen[15:0] ^ mask, 1'b0);
    gen = step(gen);
  endtask

  task automatic do_reset();
    reset_i     = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i  = 16'd0;
    clear_i     = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
  endtask

  initial begin
    int unsigned nv;
    int unsigned cyc;
    logic        seen;

    do_reset();
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_bits", 32'(err_bits_o), 0);
    chk("rst_errcnt", 32'(err_count_o), 0);
    chk("rst_wcnt", 32'(word_count_o), 0);

    // clean stream, seed 1
    gen = 32'h0000_0001;
    for (int i = 0; i < 16; i++) send(16'h0000);
    chk("lock_pre", 32'(locked_o), 0);
    send(16'h0000);
    chk("lock_at17", 32'(locked_o), 1);
    for (int i = 0; i < 1000; i++) send(16'h0000);
    chk("clean_err", 32'(err_count_o), 0);
    chk("clean_words", 32'(word_count_o), 1000);

    drive(1'b0, 16'd0, 1'b1);
    chk("clr_err", 32'(err_count_o), 0);
    chk("clr_words", 32'(word_count_o), 0);
    chk("clr_lock", 32'(locked_o), 1);

    // single flipped bit on word 50
    for (int i = 0; i < 49; i++) send(16'h0000);
    send(16'h0008);
    chk("flip_err", 32'(err_o), 1);
    chk("flip_bits", 32'(err_bits_o), 1);
    chk("flip_cnt", 32'(err_count_o), 1);
    chk("flip_lock", 32'(locked_o), 1);
    send(16'h0000);
    chk("after_err", 32'(err_o), 0);
    chk("after_bits", 32'(err_bits_o), 0);
    chk("after_cnt", 32'(err_count_o), 1);
    chk("after_words", 32'(word_count_o), 51);

    // four inverted words drop lock
    drive(1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) send(16'hFFFF);
    chk("inv3_lock", 32'(locked_o), 1);
    send(16'hFFFF);
    chk("inv4_lock", 32'(locked_o), 0);
    chk("inv4_cnt", 32'(err_count_o), 64);
    chk("inv4_bits", 32'(err_bits_o), 16);
    chk("inv4_words", 32'(word_count_o), 4);
    for (int i = 0; i < 16; i++) send(16'h0000);
    chk("relock_pre", 32'(locked_o), 0);
    send(16'h0000);
    chk("relock", 32'(locked_o), 1);
    send(16'h0000);
    chk("relock_cnt", 32'(err_count_o), 64);
    chk("relock_words", 32'(word_count_o), 5);

    // gapped valid
    do_reset();
    gen = 32'h0000_0001;
    nv  = 0;
    cyc = 0;
    while (nv < 217 && cyc < 3000) begin
      if ($urandom_range(0, 2) != 0) begin
        send(16'h0000);
        nv++;
      end else begin
        drive(1'b0, 16'hA5A5, 1'b0);
      end
      cyc++;
    end
    chk("gap_budget", nv, 217);
    chk("gap_lock", 32'(locked_o), 1);
    chk("gap_err", 32'(err_count_o), 0);
    chk("gap_words", 32'(word_count_o), 200);

    // all-zero stream never locks
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'd0, 1'b0);
      seen = seen | locked_o;
    end
    chk("zero_seen", 32'(seen), 0);
    chk("zero_words", 32'(word_count_o), 0);

    // saturation, clear and async reset
    do_reset();
    gen = 32'h0000_0001;
    for (int i = 0; i < 17; i++) send(16'h0000);
    for (int r = 0; r < 1400; r++) begin
      for (int k = 0; k < 3; k++) send(16'hFFFF);
      send(16'h0000);
    end
    chk("sat_cnt", 32'(err_count_o), 32'hFFFF);
    chk("sat_lock", 32'(locked_o), 1);
    chk("sat_words", 32'(word_count_o), 5600);
    send(16'hFFFF);
    chk("sat_hold", 32'(err_count_o), 32'hFFFF);
    chk("sat_words2", 32'(word_count_o), 5601);
    drive(1'b1, gen[15:0] ^ 16'hFFFF, 1'b1);
    gen = step(gen);
    chk("clrchk_err", 32'(err_count_o), 0);
    chk("clrchk_words", 32'(word_count_o), 0);
    chk("clrchk_pulse", 32'(err_o), 1);
    send(16'hFFFF);
    chk("post_clr_cnt", 32'(err_count_o), 16);
    chk("post_clr_lock", 32'(locked_o), 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("arst_lock", 32'(locked_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_bits", 32'(err_bits_o), 0);
    chk("arst_cnt", 32'(err_count_o), 0);
    chk("arst_words", 32'(word_count_o), 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
